// File: rtl/exu_lsu_ctrl.sv
// Load/store unit for the EXU stage: effective address generation, natural
// alignment check, single-outstanding memory transaction over a valid/ready
// request bus and a valid-only response bus, store lane alignment with byte
// strobes, and load data extraction with sign/zero extension.
module exu_lsu_ctrl #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lsu_en,
   output logic                 lsu_ready,
   input  logic                 lsu_store,
   input  logic [1:0]           lsu_size,
   input  logic                 lsu_unsigned,
   input  logic [XLEN-1:0]      src1,
   input  logic [XLEN-1:0]      imm,
   input  logic [XLEN-1:0]      src2,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [ADDR_W-1:0]    mem_req_addr,
   output logic                 mem_req_wen,
   output logic [DATA_W-1:0]    mem_req_wdata,
   output logic [DATA_W/8-1:0]  mem_req_wstrb,
   input  logic                 mem_rsp_valid,
   input  logic [DATA_W-1:0]    mem_rsp_rdata,
   output logic                 lsu_done,
   output logic [XLEN-1:0]      lsu_rdata,
   output logic                 lsu_misalign
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Contiguous strobe of (1 << sz) bytes starting at lane 0.
   function automatic logic [NB-1:0] strb_mask(input logic [1:0] sz);
      logic [NB-1:0] m;
      for (int i = 0; i < NB; i++) begin
         m[i] = (i < (1 << sz));
      end
      return m;
   endfunction

   // Keep the low (8 << sz) bits of a lane-shifted word and extend to XLEN.
   function automatic logic [XLEN-1:0] ext_load(input logic [DATA_W-1:0] w,
                                                input logic [1:0]        sz,
                                                input logic              u);
      logic [XLEN-1:0] r;
      case (sz)
         2'd0:    r = ({XLEN{~u & w[7]}}  & ~XLEN'(8'hFF))         | XLEN'(w[7:0]);
         2'd1:    r = ({XLEN{~u & w[15]}} & ~XLEN'(16'hFFFF))      | XLEN'(w[15:0]);
         2'd2:    r = ({XLEN{~u & w[31]}} & ~XLEN'(32'hFFFF_FFFF)) | XLEN'(w[31:0]);
         default: r = w[XLEN-1:0];
      endcase
      return r;
   endfunction

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]       wstrb_q, wstrb_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic                mis_q, mis_d;
   logic                valid_q, done_q, ready_q;

   logic [XLEN-1:0]     ea_full_s;
   logic [ADDR_W-1:0]   ea_s;
   logic [OFF_W-1:0]    off_s;
   logic                mis_s;
   logic                accept_s;

   assign ea_full_s = src1 + imm;
   assign ea_s      = ea_full_s[ADDR_W-1:0];
   assign off_s     = ea_s[OFF_W-1:0];
   assign accept_s  = (state_q == S_IDLE) && lsu_en;

   // Natural alignment check; doubleword is illegal on a 32-bit datapath.
   always_comb begin
      case (lsu_size)
         2'd0:    mis_s = 1'b0;
         2'd1:    mis_s = ea_full_s[0];
         2'd2:    mis_s = |ea_full_s[1:0];
         2'd3:    mis_s = (XLEN == 32) ? 1'b1 : |ea_full_s[2:0];
         default: mis_s = 1'b1;
      endcase
   end

   // Next-state logic of the transaction FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (lsu_en) state_d = mis_s ? S_DONE : S_REQ;
            else        state_d = S_IDLE;
         end
         S_REQ: begin
            if (mem_req_ready) state_d = wen_q ? S_DONE : S_WAIT;
            else               state_d = S_REQ;
         end
         S_WAIT: begin
            if (mem_rsp_valid) state_d = S_DONE;
            else               state_d = S_WAIT;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture at accept, store-result clear at handshake, load capture on response.
   always_comb begin
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      size_d  = size_q;
      uns_d   = uns_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      mis_d   = 1'b0;
      if (accept_s) begin
         addr_d  = ea_s;
         wen_d   = lsu_store;
         wdata_d = DATA_W'(src2) << {off_s, 3'b000};
         wstrb_d = lsu_store ? (strb_mask(lsu_size) << off_s) : {NB{1'b0}};
         size_d  = lsu_size;
         uns_d   = lsu_unsigned;
         off_d   = off_s;
         mis_d   = mis_s;
         if (mis_s) rdata_d = {XLEN{1'b0}};
         else       rdata_d = rdata_q;
      end else if ((state_q == S_REQ) && mem_req_ready && wen_q) begin
         rdata_d = {XLEN{1'b0}};
      end else if ((state_q == S_WAIT) && mem_rsp_valid) begin
         rdata_d = ext_load(mem_rsp_rdata >> {off_q, 3'b000}, size_q, uns_q);
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= {ADDR_W{1'b0}};
         wen_q   <= 1'b0;
         wdata_q <= {DATA_W{1'b0}};
         wstrb_q <= {NB{1'b0}};
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         off_q   <= {OFF_W{1'b0}};
         rdata_q <= {XLEN{1'b0}};
         mis_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         valid_q <= (state_d == S_REQ);
         done_q  <= (state_d == S_DONE);
         ready_q <= (state_d == S_IDLE);
      end
   end

   assign lsu_ready     = ready_q;
   assign mem_req_valid = valid_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wstrb = wstrb_q;
   assign lsu_done      = done_q;
   assign lsu_rdata     = rdata_q;
   assign lsu_misalign  = mis_q;

endmodule
